// File: rtl/uart_arb_pkg.sv
// Shared constants, state encoding and round-robin pick for the UART line arbiter.
package uart_arb_pkg;

  localparam logic [7:0] LF = 8'h0A;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    TERM  = 2'd2
  } state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_REQ0 = 2'b01;
  localparam logic [1:0] GNT_REQ1 = 2'b10;

  // On a tie the requester that did not own the previous line wins.
  function automatic logic [1:0] rr_pick(input logic v0, input logic v1, input logic [1:0] last);
    logic [1:0] pick;
    pick = GNT_NONE;
    if (v0 && v1)
      pick = (last == GNT_REQ0) ? GNT_REQ1 : GNT_REQ0;
    else if (v0)
      pick = GNT_REQ0;
    else if (v1)
      pick = GNT_REQ1;
    return pick;
  endfunction

endpackage

// File: rtl/uart_tx_line_arbiter.sv
// Arbitrates two byte streams onto one UART transmitter a whole line at a time,
// forcing an LF onto the wire when the owning requester stalls for too long.
module uart_tx_line_arbiter
  import uart_arb_pkg::*;
#(
  parameter int IDLE_TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] req0_data,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req1_data,
  input  logic       req1_valid,
  output logic       req1_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [1:0] grant_o,
  output logic       timeout_o
);

  localparam logic [15:0] TIMEOUT_LIM = 16'(IDLE_TIMEOUT);

  state_t      state, state_nxt;
  logic [1:0]  grant_q, grant_nxt;
  logic [1:0]  last_q, last_nxt;
  logic [15:0] stall_q, stall_nxt;
  logic        own_valid;
  logic [7:0]  own_data;
  logic [1:0]  pick;

  always_comb begin
    own_valid = 1'b0;
    own_data  = 8'h00;
    if (grant_q == GNT_REQ0) begin
      own_valid = req0_valid;
      own_data  = req0_data;
    end else if (grant_q == GNT_REQ1) begin
      own_valid = req1_valid;
      own_data  = req1_data;
    end
  end

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant_q;
    last_nxt   = last_q;
    stall_nxt  = stall_q;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    timeout_o  = 1'b0;
    pick       = rr_pick(req0_valid, req1_valid, last_q);
    case (state)
      IDLE: begin
        if (pick != GNT_NONE) begin
          grant_nxt = pick;
          last_nxt  = pick;
          stall_nxt = 16'd0;
          state_nxt = BURST;
        end
      end
      BURST: begin
        tx_valid   = own_valid;
        tx_data    = own_data;
        req0_ready = (grant_q == GNT_REQ0) && tx_ready;
        req1_ready = (grant_q == GNT_REQ1) && tx_ready;
        if (own_valid && tx_ready) begin
          stall_nxt = 16'd0;
          if (own_data == LF) begin
            state_nxt = IDLE;
            grant_nxt = GNT_NONE;
          end
        end else if (!own_valid) begin
          // A busy transmitter is not a stall; only a silent owner counts.
          stall_nxt = stall_q + 16'd1;
          if (stall_nxt == TIMEOUT_LIM)
            state_nxt = TERM;
        end
      end
      TERM: begin
        // The closing LF is generated here; the owner's byte stays pending.
        tx_valid = 1'b1;
        tx_data  = LF;
        if (tx_ready) begin
          timeout_o = 1'b1;
          state_nxt = IDLE;
          grant_nxt = GNT_NONE;
          stall_nxt = 16'd0;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = GNT_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      grant_q <= GNT_NONE;
      last_q  <= GNT_REQ1;
      stall_q <= 16'd0;
    end else begin
      state   <= state_nxt;
      grant_q <= grant_nxt;
      last_q  <= last_nxt;
      stall_q <= stall_nxt;
    end
  end

  assign grant_o = grant_q;

endmodule

// File: doc/uart_tx_line_arbiter.md
UART_TX_LINE_ARBITER -- requirements
Module: uart_tx_line_arbiter

Interface
REQ-001 Parameter IDLE_TIMEOUT, default 4096, meaning the number of stalled cycles inside a line before forced termination (legal range 1..65535).
REQ-002 clk  input  1  system clock (50 MHz); all logic is rising-edge.
REQ-003 rstn  input  1  asynchronous active-low reset.
REQ-004 req0_data  input  8  byte offered by requester 0 (command response path).
REQ-005 req0_valid  input  1  requester 0 byte valid.
REQ-006 req0_ready  output  1  requester 0 byte accepted when high together with req0_valid.
REQ-007 req1_data  input  8  byte offered by requester 1 (status/telemetry path).
REQ-008 req1_valid  input  1  requester 1 byte valid.
REQ-009 req1_ready  output  1  requester 1 byte accepted when high together with req1_valid.
REQ-010 tx_data  output  8  byte presented to the shared UART transmitter.
REQ-011 tx_valid  output  1  tx_data valid.
REQ-012 tx_ready  input  1  transmitter accepts the byte on tx_valid & tx_ready.
REQ-013 grant_o  output  2  one-hot current owner: 01 = req0, 10 = req1, 00 = none.
REQ-014 timeout_o  output  1  one-cycle pulse when a line is force-terminated.

Function
REQ-015 The FSM SHALL have the states IDLE, BURST and TERM.
REQ-016 IDLE: tx_valid=0 and both readies=0; if any reqN_valid=1, the FSM SHALL register a grant and enter BURST on the next edge (1-cycle arbitration latency).
REQ-017 Arbitration SHALL be round-robin: if both requesters are valid, grant the one not granted last; if one is valid, grant it; last_grant SHALL update on every grant.
REQ-018 BURST with owner N: tx_valid=reqN_valid, tx_data=reqN_data and reqN_ready=tx_ready, combinationally; the non-owner's ready SHALL be 0.
REQ-019 A transfer SHALL occur on tx_valid & tx_ready; a transferred byte equal to 0x0A (LF) SHALL return the FSM to IDLE and clear grant_o on the next edge.
REQ-020 Lines SHALL never interleave: ownership persists across bytes until LF or timeout, regardless of the non-owner's valid.
REQ-021 A 16-bit stall counter SHALL increment in BURST on each cycle with reqN_valid=0, and clear on any transfer and on entering BURST.
REQ-022 Cycles with reqN_valid=1 and tx_ready=0 (transmitter busy) SHALL hold the counter unchanged.
REQ-023 When the counter reaches IDLE_TIMEOUT, the FSM SHALL enter TERM.
REQ-024 TERM: tx_valid=1, tx_data=0x0A, both readies=0, grant_o held; on tx_ready the FSM SHALL go to IDLE and timeout_o SHALL pulse high for exactly that one cycle.
REQ-025 If, in the cycle the counter reaches IDLE_TIMEOUT, reqN_valid is high and a transfer occurs, the transfer SHALL win and the counter SHALL clear.
REQ-026 The LF sent in TERM SHALL NOT be taken from either requester; the owner's pending byte remains unaccepted.
REQ-027 Back-to-back lines: after LF the FSM SHALL spend one IDLE cycle before the next grant.

Reset
REQ-028 Asserting rstn low at any time, including mid-line, SHALL immediately force the state to IDLE and set grant_o=00, tx_valid=0, both readies=0, timeout_o=0, counter=0 and last_grant=req1 (so req0 wins the first tie).
REQ-029 Reset deassertion SHALL be synchronised externally; the block SHALL not emit a partial line after reset.

Structure
REQ-030 Package uart_arb_pkg SHALL hold the LF constant (8'h0A), the state enum (IDLE/BURST/TERM) and the grant encodings.
REQ-031 The block SHALL be a single module with no sub-modules; the round-robin decision may be a function in the package.

Verification
REQ-032 Scenario: req0 sends "OK\n" with tx_ready=1 -> grant_o=01 one cycle after valid, tx_data sequence 4F 4B 0A, then grant_o=00.
REQ-033 Scenario: req0 and req1 both valid from IDLE after reset -> req0 is granted first; its full line is sent, then req1 is granted after one IDLE cycle.
REQ-034 Scenario: req1 is mid-line and req0 asserts valid -> no req0 byte appears until req1's 0x0A has been transferred.
REQ-035 Scenario: IDLE_TIMEOUT=16; req0 sends "AB" and drops valid -> after 16 stall cycles tx_data=0A (TERM), timeout_o pulses once, grant_o returns to 00.
REQ-036 Scenario: tx_ready held low for 100 cycles with req0_valid=1 and IDLE_TIMEOUT=16 -> no timeout; the byte transfers when tx_ready rises.
REQ-037 Scenario: rstn is pulsed low mid-line -> outputs are 0 immediately, and the next grant starts a fresh line.
